// File: rtl/fp_mul_dispatch.sv
// Operand FIFO and issue controller for a start/busy/done floating-point multiplier.
// Products (or a quiet-NaN timeout marker) are returned in request order on a valid/ready port.
module fp_mul_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_op1,
  input  logic [31:0]                  req_op2,
  output logic                         mul_start,
  output logic [31:0]                  op1,
  output logic [31:0]                  op2,
  input  logic                         mul_busy,
  input  logic                         mul_done,
  input  logic [31:0]                  mul_result,
  output logic                         mul_serv,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [31:0]                  res_data,
  output logic                         res_err,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [31:0]    op1_q, op1_d, op2_q, op2_d;
  logic [31:0]    res_data_q, res_data_d;
  logic           res_err_q, res_err_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           push_s, pop_s, serv_s, ready_s;

  // Ready looks at the pre-pop count, so a full FIFO never accepts even while popping.
  assign ready_s = !n_rst && (count_q < CW'(DEPTH));
  assign push_s  = req_valid && ready_s;

  // Next-state, operand load, watchdog and result capture.
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    wd_d       = wd_q;
    pop_s      = 1'b0;
    serv_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != CW'(0)) && !mul_busy) begin
          state_d = S_ISSUE;
          pop_s   = 1'b1;
          op1_d   = mem_q[rd_ptr_q][63:32];
          op2_d   = mem_q[rd_ptr_q][31:0];
          wd_d    = WW'(0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        wd_d = wd_q + WW'(1);
        // A done arriving on the last allowed cycle still counts as a real result.
        if (mul_done) begin
          serv_s     = 1'b1;
          res_data_d = mul_result;
          res_err_d  = 1'b0;
          state_d    = S_HOLD;
        end else if (wd_q == WW'(TIMEOUT-1)) begin
          res_data_d = 32'h7FC0_0000;
          res_err_d  = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller and result registers.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= S_IDLE;
      op1_q      <= 32'h0;
      op2_q      <= 32'h0;
      res_data_q <= 32'h0;
      res_err_q  <= 1'b0;
      wd_q       <= WW'(0);
    end else begin
      state_q    <= state_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      wd_q       <= wd_d;
    end
  end

  // Circular operand buffer with occupancy counter.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'h0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {req_op1, req_op2};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign req_ready = ready_s;
  assign mul_start = (state_q == S_ISSUE);
  assign mul_serv  = serv_s;
  assign res_valid = (state_q == S_HOLD);
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign q_count   = count_q;

endmodule

// File: tb/tb_fp_mul_dispatch.sv
// Scoreboard bench for fp_mul_dispatch with a lookup-table multiplier model of programmable latency.
module tb_fp_mul_dispatch;
  logic        clk = 1'b0;
  logic        n_rst, req_valid, req_ready, mul_start, mul_busy, mul_serv;
  logic        res_valid, res_ready, res_err;
  logic        mul_done = 1'b0;
  logic [31:0] req_op1, req_op2, op1, op2, res_data;
  logic [31:0] mul_result = 32'h0;
  logic [2:0]  q_count;

  int tests = 0, fails = 0;
  int start_cnt = 0, serv_cnt = 0;
  int lat = 5, cnt = 0;
  bit never_done = 1'b0, pend = 1'b0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_dispatch #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .mul_start(mul_start), .op1(op1), .op2(op2),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result), .mul_serv(mul_serv),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .q_count(q_count));

  // Hand-computed single-precision products for the operand pairs used here.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FA00000 && b == 32'h3FC00000) return 32'h3FF00000;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'hC0C00000) return 32'hC0C00000;
    if (a == 32'hC0400000 && b == 32'hC0800000) return 32'h41400000;
    if (a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    return 32'hDEADBEEF;
  endfunction

  // Multiplier model: done pulses lat cycles after the start cycle.
  always @(negedge clk) begin
    mul_done = 1'b0;
    if (mul_start) begin
      pend       = !never_done;
      cnt        = lat;
      mul_result = prod(op1, op2);
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mul_done = 1'b1;
        pend     = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (mul_start) start_cnt++;
    if (mul_serv)  serv_cnt++;
  end

  // Monitor: every result transfer is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!n_rst && res_valid && res_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got data=%h err=%b, required no result", res_data, res_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({res_err, res_data} !== e) begin
          fails++;
          $display("FAIL result: got data=%h err=%b, required data=%h err=%b",
                   res_data, res_err, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] e);
    bit acc = 1'b0;
    req_op1 = a; req_op2 = b; req_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc) exp_q.push_back(e);
    else begin
      tests++; fails++;
      $display("FAIL send_timeout: got no accept, required accept of %h,%h", a, b);
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mul_start) return;
    end
    tests++; fails++;
    $display("FAIL start_timeout: got no mul_start, required mul_start");
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    int k;
    n_rst = 1'b1; req_valid = 1'b1; res_ready = 1'b0; mul_busy = 1'b0;
    req_op1 = 32'h3FA00000; req_op2 = 32'h3FC00000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_q_count", q_count, 32'd0);
    chk("rst_mul_start", mul_start, 32'd0);
    chk("rst_mul_serv", mul_serv, 32'd0);
    chk("rst_res_valid", res_valid, 32'd0);
    chk("rst_res_err", res_err, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    req_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 32'd1);

    // Single op, latency 5, result held under backpressure.
    @(posedge clk); #1;
    start_cnt = 0; serv_cnt = 0;
    req_op1 = 32'h3FA00000; req_op2 = 32'h3FC00000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back({1'b0, 32'h3FF00000});
    chk("one_qcount_after_accept", q_count, 32'd1);
    chk("one_start_before_issue", mul_start, 32'd0);
    @(posedge clk); #1;
    chk("one_start_high", mul_start, 32'd1);
    chk("one_op1", op1, 32'h3FA00000);
    chk("one_op2", op2, 32'h3FC00000);
    chk("one_qcount_after_pop", q_count, 32'd0);
    @(posedge clk); #1;
    chk("one_start_low", mul_start, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("one_valid_early", res_valid, 32'd0);
    @(posedge clk); #1;
    chk("one_valid_rise", res_valid, 32'd1);
    chk("one_data", res_data, 32'h3FF00000);
    chk("one_err", res_err, 32'd0);
    chk("one_start_pulses", start_cnt, 32'd1);
    chk("one_serv_pulses", serv_cnt, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 32'd1);
      chk("hold_data", res_data, 32'h3FF00000);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("one_valid_drop", res_valid, 32'd0);
    chk("one_serv_total", serv_cnt, 32'd1);

    // Full FIFO with the multiplier busy, then drain in order.
    lat = 3; mul_busy = 1'b1;
    fork
      begin
        send(32'h3FA00000, 32'h3FC00000, {1'b0, 32'h3FF00000});
        send(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
        send(32'h3F800000, 32'hC0C00000, {1'b0, 32'hC0C00000});
        send(32'hC0400000, 32'hC0800000, {1'b0, 32'h41400000});
        send(32'h40000000, 32'h40000000, {1'b0, 32'h40800000});
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("full_qcount", q_count, 32'd4);
        chk("full_ready", req_ready, 32'd0);
        chk("full_no_issue", mul_start, 32'd0);
        mul_busy = 1'b0;
      end
    join
    drain();

    // Timeout on a silent multiplier, then a normal op behind it.
    never_done = 1'b1; mul_busy = 1'b1;
    send(32'h40000000, 32'h40400000, {1'b1, 32'h7FC00000});
    send(32'h3FA00000, 32'h3FC00000, {1'b0, 32'h3FF00000});
    mul_busy = 1'b0;
    wait_start();
    @(posedge clk); #1;
    chk("to_start_low", mul_start, 32'd0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      k++;
      if (res_valid) break;
    end
    chk("to_latency", k, 32'd8);
    chk("to_err", res_err, 32'd1);
    chk("to_data", res_data, 32'h7FC00000);
    never_done = 1'b0; lat = 2;
    drain();

    // Done on the last allowed WAIT cycle beats the timeout.
    lat = 8;
    send(32'h3F800000, 32'hC0C00000, {1'b0, 32'hC0C00000});
    drain();

    // Reset mid-WAIT with two queued, late done ignored, then recovery.
    lat = 6; mul_busy = 1'b1;
    send(32'h3FA00000, 32'h3FC00000, {1'b0, 32'h3FF00000});
    send(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    send(32'hC0400000, 32'hC0800000, {1'b0, 32'h41400000});
    mul_busy = 1'b0;
    wait_start();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_qcount", q_count, 32'd2);
    n_rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_qcount", q_count, 32'd0);
    chk("mid_rst_ready", req_ready, 32'd0);
    chk("mid_rst_start", mul_start, 32'd0);
    chk("mid_rst_valid", res_valid, 32'd0);
    chk("mid_rst_op1", op1, 32'd0);
    chk("mid_rst_data", res_data, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b0;
    serv_cnt = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid) k++;
    end
    chk("late_done_serv", serv_cnt, 32'd0);
    chk("late_done_valid", k, 32'd0);
    chk("late_done_qcount", q_count, 32'd0);
    lat = 4;
    send(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000});
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
